// File: rtl/serial_3wire_pkg.sv
//============================================================================
// Module      : serial_3wire_pkg
// Description : Shared types, defaults and helpers for the 3-wire serial
//               transceiver (frame / bit strobe / data).
//               Optional parity: define SERIAL_3WIRE_PARITY_EN to append one
//               even-parity bit to every word.
// Contents    : tx_state_t    - TX serializer state encoding
//               DEFAULT_*     - default word width and bit period
//               frame_bits()  - number of serial bits per frame
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package serial_3wire_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_BIT_PERIOD = 4;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  // Bits carried by one frame: the data word, plus the parity bit when enabled.
  function automatic int unsigned frame_bits(input int unsigned data_width);
`ifdef SERIAL_3WIRE_PARITY_EN
    return data_width + 1;
`else
    return data_width;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_3wire_ser.sv
//============================================================================
// Module      : serial_3wire_ser
// Description : TX serializer. Latches a word on start and shifts it out
//               MSB-first, one bit per BIT_PERIOD cycles, with the bit strobe
//               in the last cycle of every bit period. With
//               SERIAL_3WIRE_PARITY_EN defined an even-parity bit follows
//               the LSB.
// Ports       : clk, rst_n (async, low), rst_syn (sync, high)
//               data [DATA_WIDTH-1:0] / start  - word and one-cycle request
//               busy, done                     - status / end-of-frame pulse
//               frame, bit_en, ser_out         - serial line outputs
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_3wire_ser
  import serial_3wire_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_syn,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  frame,
  output logic                  bit_en,
  output logic                  ser_out
);

  localparam int unsigned NBITS = frame_bits(DATA_WIDTH);
  localparam int unsigned CYC_W = $clog2(BIT_PERIOD);
  localparam int unsigned IDX_W = $clog2(NBITS);

  tx_state_t        state;
  logic [NBITS-1:0] payload;
  logic [NBITS-1:0] shreg;    // remaining bits, next one at the MSB
  logic [CYC_W-1:0] cyc;      // cycle within the current bit period
  logic [IDX_W-1:0] idx;      // index of the bit currently on the line

  always_comb begin
`ifdef SERIAL_3WIRE_PARITY_EN
    payload = {data, ^data};
`else
    payload = data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      shreg   <= '0;
      cyc     <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      frame   <= 1'b0;
      bit_en  <= 1'b0;
      ser_out <= 1'b0;
    end else if (rst_syn) begin
      state   <= TX_IDLE;
      shreg   <= '0;
      cyc     <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      frame   <= 1'b0;
      bit_en  <= 1'b0;
      ser_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          // Requests in the done cycle land here, so back-to-back works.
          if (start) begin
            state   <= TX_SEND;
            busy    <= 1'b1;
            frame   <= 1'b1;
            ser_out <= payload[NBITS-1];
            shreg   <= payload << 1;
            cyc     <= '0;
            idx     <= '0;
            bit_en  <= 1'b0;
          end
        end
        TX_SEND: begin
          if (cyc == CYC_W'(BIT_PERIOD - 1)) begin
            cyc    <= '0;
            bit_en <= 1'b0;
            if (idx == IDX_W'(NBITS - 1)) begin
              state   <= TX_IDLE;
              busy    <= 1'b0;
              frame   <= 1'b0;
              ser_out <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx     <= idx + IDX_W'(1);
              ser_out <= shreg[NBITS-1];
              shreg   <= shreg << 1;
            end
          end else begin
            cyc    <= cyc + CYC_W'(1);
            // Strobe lands in the final cycle of the bit period.
            bit_en <= (cyc == CYC_W'(BIT_PERIOD - 2));
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_3wire_transceiver.sv
//============================================================================
// Module      : serial_3wire_transceiver
// Description : Word-serial transceiver over frame / bit strobe / data.
//               TX serialises DATA_WIDTH words MSB-first (serial_3wire_ser);
//               RX deserialises incoming frames and flags malformed ones.
//               Define SERIAL_3WIRE_PARITY_EN to add an even-parity bit on
//               TX and check it on RX.
// Ports       : clk_i, rst_asy_n_i (async, low), rst_syn_i (sync, high)
//               tx_data_i/tx_data_en_i          - word and send request
//               tx_busy_o/tx_done_o             - TX status
//               tx_frame_o/tx_bit_en_o/tx_o     - TX line
//               rx_frame_i/rx_bit_en_i/rx_i     - RX line (clk_i domain)
//               rx_data_o/rx_data_en_o/rx_error_o - received word / status
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_3wire_transceiver
  import serial_3wire_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
  input  logic                  clk_i,
  input  logic                  rst_asy_n_i,
  input  logic                  rst_syn_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_data_en_i,
  output logic                  tx_busy_o,
  output logic                  tx_done_o,
  output logic                  tx_frame_o,
  output logic                  tx_bit_en_o,
  output logic                  tx_o,
  input  logic                  rx_frame_i,
  input  logic                  rx_bit_en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_data_en_o,
  output logic                  rx_error_o
);

  localparam int unsigned NBITS = frame_bits(DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 3);

  serial_3wire_ser #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_PERIOD (BIT_PERIOD)
  ) u_ser (
    .clk     (clk_i),
    .rst_n   (rst_asy_n_i),
    .rst_syn (rst_syn_i),
    .data    (tx_data_i),
    .start   (tx_data_en_i),
    .busy    (tx_busy_o),
    .done    (tx_done_o),
    .frame   (tx_frame_o),
    .bit_en  (tx_bit_en_o),
    .ser_out (tx_o)
  );

  logic                  frame_q;
  logic [NBITS-1:0]      rx_shreg;
  logic [CNT_W-1:0]      rx_cnt;
  logic                  frame_end;
  logic                  rx_good;
  logic [DATA_WIDTH-1:0] rx_word;

  // Falling edge of the frame line; frame_q is cleared by reset, so a frame
  // cut short by reset never produces an end-of-frame event.
  assign frame_end = frame_q & ~rx_frame_i;

  always_comb begin
`ifdef SERIAL_3WIRE_PARITY_EN
    rx_word = rx_shreg[NBITS-1:1];
    // Even parity: XOR over data plus parity bit must be zero.
    rx_good = (rx_cnt == CNT_W'(NBITS)) && !(^rx_shreg);
`else
    rx_word = rx_shreg;
    rx_good = (rx_cnt == CNT_W'(NBITS));
`endif
  end

  always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
    if (!rst_asy_n_i) begin
      frame_q      <= 1'b0;
      rx_shreg     <= '0;
      rx_cnt       <= '0;
      rx_data_o    <= '0;
      rx_data_en_o <= 1'b0;
      rx_error_o   <= 1'b0;
    end else if (rst_syn_i) begin
      frame_q      <= 1'b0;
      rx_shreg     <= '0;
      rx_cnt       <= '0;
      rx_data_o    <= '0;
      rx_data_en_o <= 1'b0;
      rx_error_o   <= 1'b0;
    end else begin
      frame_q      <= rx_frame_i;
      rx_data_en_o <= 1'b0;
      rx_error_o   <= 1'b0;
      if (frame_end) begin
        rx_cnt <= '0;
        if (rx_good) begin
          rx_data_o    <= rx_word;
          rx_data_en_o <= 1'b1;
        end else begin
          rx_error_o <= 1'b1;
        end
      end else if (rx_frame_i && rx_bit_en_i) begin
        rx_shreg <= {rx_shreg[NBITS-2:0], rx_i};
        // Saturate just past the valid lengths so overlong frames stay bad.
        if (rx_cnt != CNT_W'(DATA_WIDTH + 2)) begin
          rx_cnt <= rx_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_3wire_transceiver.sv
//============================================================================
// Module      : tb_serial_3wire_transceiver
// Description : Self-checking bench for serial_3wire_transceiver. A table of
//               loopback and directly-driven frames, followed by hand-written
//               multi-cycle sequences (busy request, done-cycle request,
//               stray strobes, resets mid-frame, parity corruption when
//               SERIAL_3WIRE_PARITY_EN is defined).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_3wire_transceiver;

  localparam int W  = 32;
  localparam int BP = 4;
`ifdef SERIAL_3WIRE_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic          clk = 1'b0;
  logic          rst_asy_n, rst_syn;
  logic [W-1:0]  tx_data;
  logic          tx_data_en;
  logic          tx_busy, tx_done, tx_frame, tx_bit_en, tx_o;
  logic          rx_frame, rx_bit_en, rx_in;
  logic [W-1:0]  rx_data;
  logic          rx_data_en, rx_error;

  logic loop, flip, drv_frame, drv_bit_en, drv_rx;

  assign rx_frame  = loop ? tx_frame  : drv_frame;
  assign rx_bit_en = loop ? tx_bit_en : drv_bit_en;
  assign rx_in     = loop ? (tx_o ^ flip) : drv_rx;

  always #5 clk = ~clk;

  serial_3wire_transceiver #(.DATA_WIDTH(W), .BIT_PERIOD(BP)) dut (
    .clk_i        (clk),
    .rst_asy_n_i  (rst_asy_n),
    .rst_syn_i    (rst_syn),
    .tx_data_i    (tx_data),
    .tx_data_en_i (tx_data_en),
    .tx_busy_o    (tx_busy),
    .tx_done_o    (tx_done),
    .tx_frame_o   (tx_frame),
    .tx_bit_en_o  (tx_bit_en),
    .tx_o         (tx_o),
    .rx_frame_i   (rx_frame),
    .rx_bit_en_i  (rx_bit_en),
    .rx_i         (rx_in),
    .rx_data_o    (rx_data),
    .rx_data_en_o (rx_data_en),
    .rx_error_o   (rx_error)
  );

  int n_cmp = 0, n_fail = 0;
  int n_bit_en = 0, n_done = 0, n_rx_en = 0, n_rx_err = 0;
  int cur_len = 0, last_len = 0;

  always @(negedge clk) begin
    if (tx_bit_en)  n_bit_en++;
    if (tx_done)    n_done++;
    if (rx_data_en) n_rx_en++;
    if (rx_error)   n_rx_err++;
    if (tx_frame) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    @(negedge clk);
    tx_data    = w;
    tx_data_en = 1'b1;
    @(negedge clk);
    tx_data_en = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < NB * BP + 50; k++) begin
      @(negedge clk);
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_frame(input logic [W-1:0] w, input int nbits);
    logic [NB-1:0] pl;
`ifdef SERIAL_3WIRE_PARITY_EN
    pl = {w, ^w};
`else
    pl = w;
`endif
    @(negedge clk);
    drv_frame = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      drv_rx     = (i < NB) ? pl[NB-1-i] : 1'b0;
      drv_bit_en = 1'b0;
      repeat (BP - 1) @(negedge clk);
      drv_bit_en = 1'b1;
      @(negedge clk);
      drv_bit_en = 1'b0;
    end
    drv_frame = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    bit          loopback;
    logic [W-1:0] word;
    int          delta;   // strobes relative to the expected count
    bit          ok;
  } vec_t;

  vec_t         vecs [8];
  logic [W-1:0] exp_data;
  int           b_bit, b_done, b_en, b_err, seen;
  bit           got;

  initial begin
    vecs[0] = '{1'b1, 32'hAACC5533,  0, 1'b1};
    vecs[1] = '{1'b1, 32'h3355CCAA,  0, 1'b1};
    vecs[2] = '{1'b1, 32'hFFFFFFFF,  0, 1'b1};
    vecs[3] = '{1'b1, 32'h00000000,  0, 1'b1};
    vecs[4] = '{1'b0, 32'h12345678, -1, 1'b0};
    vecs[5] = '{1'b0, 32'h0F1E2D3C,  0, 1'b1};
    vecs[6] = '{1'b0, 32'hA5A5A5A5,  1, 1'b0};
    vecs[7] = '{1'b0, 32'h80000001,  0, 1'b1};

    rst_asy_n = 1'b0; rst_syn = 1'b0;
    tx_data = '0; tx_data_en = 1'b0;
    loop = 1'b1; flip = 1'b0;
    drv_frame = 1'b0; drv_bit_en = 1'b0; drv_rx = 1'b0;
    exp_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {tx_busy, tx_done, tx_frame, tx_bit_en, tx_o, rx_data_en, rx_error, rx_data}, 64'h0);
    rst_asy_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- table-driven frames ----------------
    for (int i = 0; i < 8; i++) begin
      b_bit = n_bit_en; b_done = n_done; b_en = n_rx_en; b_err = n_rx_err;
      if (vecs[i].loopback) begin
        loop = 1'b1;
        @(negedge clk);
        tx_data = vecs[i].word; tx_data_en = 1'b1;
        @(negedge clk);
        tx_data_en = 1'b0;
        check("busy_frame_after_req", {tx_busy, tx_frame}, 2'b11);
        wait_done(got);
        check("done_seen", got, 1);
        check("idle_at_done", {tx_busy, tx_frame, tx_o}, 3'b000);
        repeat (4) @(negedge clk);
        check("bit_strobes", n_bit_en - b_bit, NB);
        check("done_pulses", n_done - b_done, 1);
        check("frame_len", last_len, NB * BP);
        #200;
      end else begin
        loop = 1'b0;
        drive_frame(vecs[i].word, NB + vecs[i].delta);
        loop = 1'b1;
      end
      if (vecs[i].ok) exp_data = vecs[i].word;
      check("rx_en_pulses", n_rx_en - b_en, vecs[i].ok ? 1 : 0);
      check("rx_err_pulses", n_rx_err - b_err, vecs[i].ok ? 0 : 1);
      check("rx_data", rx_data, exp_data);
    end

    // ---------------- request while busy ----------------
    b_done = n_done; b_en = n_rx_en; b_err = n_rx_err;
    send_word(32'h0BADF00D);
    repeat (40) @(negedge clk);
    tx_data = 32'h12345678; tx_data_en = 1'b1;
    @(negedge clk);
    tx_data_en = 1'b0;
    wait_done(got);
    check("busy_req_done_seen", got, 1);
    repeat (NB * BP + 20) @(negedge clk);
    exp_data = 32'h0BADF00D;
    check("busy_req_rx_data", rx_data, exp_data);
    check("busy_req_rx_en", n_rx_en - b_en, 1);
    check("busy_req_done", n_done - b_done, 1);
    check("busy_req_idle", tx_busy, 1'b0);

    // ---------------- request in the done cycle ----------------
    b_en = n_rx_en; b_err = n_rx_err;
    send_word(32'hC0FFEE11);
    wait_done(got);
    tx_data = 32'h5A5A0F0F; tx_data_en = 1'b1;
    @(negedge clk);
    tx_data_en = 1'b0;
    check("done_cycle_req_accepted", {tx_busy, tx_frame}, 2'b11);
    wait_done(got);
    check("done_cycle_second_done", got, 1);
    repeat (4) @(negedge clk);
    exp_data = 32'h5A5A0F0F;
    check("done_cycle_rx_en", n_rx_en - b_en, 2);
    check("done_cycle_rx_data", rx_data, exp_data);
    check("done_cycle_rx_err", n_rx_err - b_err, 0);

    // ---------------- strobes outside a frame ----------------
    b_en = n_rx_en; b_err = n_rx_err;
    loop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drv_rx = 1'b1; drv_bit_en = 1'b1;
      @(negedge clk); drv_bit_en = 1'b0;
    end
    drive_frame(32'hDEADBEEF, NB);
    loop = 1'b1;
    exp_data = 32'hDEADBEEF;
    check("stray_rx_data", rx_data, exp_data);
    check("stray_rx_en", n_rx_en - b_en, 1);
    check("stray_rx_err", n_rx_err - b_err, 0);

`ifdef SERIAL_3WIRE_PARITY_EN
    // ---------------- corrupted parity bit ----------------
    b_en = n_rx_en; b_err = n_rx_err;
    seen = 0;
    send_word(32'hAACC5533);
    for (int k = 0; k < NB * BP + 50; k++) begin
      @(negedge clk);
      if (tx_bit_en) seen++;
      if (seen == NB - 1) break;
    end
    @(negedge clk);
    flip = 1'b1;
    wait_done(got);
    repeat (4) @(negedge clk);
    flip = 1'b0;
    check("parity_err", n_rx_err - b_err, 1);
    check("parity_no_en", n_rx_en - b_en, 0);
    check("parity_rx_data", rx_data, exp_data);
`endif

    // ---------------- synchronous reset mid-frame ----------------
    b_done = n_done; b_en = n_rx_en; b_err = n_rx_err;
    send_word(32'h76543210);
    repeat (20) @(negedge clk);
    rst_syn = 1'b1;
    @(negedge clk);
    rst_syn = 1'b0;
    check("sync_rst_outputs",
          {tx_busy, tx_done, tx_frame, tx_bit_en, tx_o, rx_data_en, rx_error, rx_data}, 64'h0);
    repeat (NB * BP + 10) @(negedge clk);
    check("sync_rst_no_done", n_done - b_done, 0);
    check("sync_rst_no_rx", (n_rx_en - b_en) + (n_rx_err - b_err), 0);

    // ---------------- asynchronous reset mid-frame ----------------
    b_done = n_done; b_en = n_rx_en; b_err = n_rx_err;
    send_word(32'hFEDCBA98);
    repeat (30) @(negedge clk);
    #2 rst_asy_n = 1'b0;
    #1;
    check("async_rst_outputs",
          {tx_busy, tx_done, tx_frame, tx_bit_en, tx_o, rx_data_en, rx_error, rx_data}, 64'h0);
    repeat (2) @(negedge clk);
    rst_asy_n = 1'b1;
    repeat (NB * BP + 10) @(negedge clk);
    check("async_rst_no_done", n_done - b_done, 0);
    check("async_rst_no_rx", (n_rx_en - b_en) + (n_rx_err - b_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/serial_3wire_transceiver.md
Name: serial_3wire_transceiver

Overview:
Word-serial link over three wires: frame, bit strobe, data. The TX path serialises a DATA_WIDTH word MSB-first on request. The RX path deserialises incoming frames and flags malformed ones. The block sits between a parallel register interface and an on-board or inter-FPGA 3-wire link. Both paths share one clock domain, and rx_* inputs are synchronous to clk_i.

Parameters:
DATA_WIDTH, 32, word width in bits (>=2)
BIT_PERIOD, 4, clock cycles per serial bit (>=2)

Ports:
clk_i  in  1  system clock, rising edge
rst_asy_n_i  in  1  asynchronous active-low reset
rst_syn_i  in  1  synchronous active-high reset, same effect as rst_asy_n_i
tx_data_i  in  DATA_WIDTH  word to send
tx_data_en_i  in  1  one-cycle send request
tx_busy_o  out  1  transmission in progress
tx_done_o  out  1  one-cycle pulse at end of transmission
tx_frame_o  out  1  frame line, high during a word
tx_bit_en_o  out  1  bit strobe line
tx_o  out  1  serial data line
rx_frame_i  in  1  frame line
rx_bit_en_i  in  1  bit strobe line
rx_i  in  1  serial data line
rx_data_o  out  DATA_WIDTH  last correctly received word
rx_data_en_o  out  1  one-cycle valid pulse
rx_error_o  out  1  one-cycle malformed-frame pulse

Behaviour:
- Reset (either reset): all outputs 0; TX returns to IDLE; RX shift register and counter cleared.
- TX states: IDLE, SEND.
- IDLE: on tx_data_en_i, latch tx_data_i. Next cycle, tx_busy_o=1 and tx_frame_o=1, and the FSM enters SEND with bit index N=0.
- tx_data_en_i during SEND is ignored. A request in the same cycle that tx_done_o pulses is accepted.
- SEND: for each bit N (MSB first), tx_o holds data[W-1-N] for BIT_PERIOD cycles. tx_bit_en_o is high only in the last cycle of each bit period, so data is stable for BIT_PERIOD-1 cycles before the strobe.
- After the last bit period, tx_frame_o, tx_busy_o and tx_o go to 0 and tx_done_o pulses for one cycle in the same cycle. The FSM returns to IDLE.
- Frame length: W*BIT_PERIOD cycles, plus BIT_PERIOD when parity is enabled.
- RX: while rx_frame_i=1, each cycle with rx_bit_en_i=1 shifts rx_i into the LSB of the shift register. The bit counter increments, saturating at W+2.
- rx_bit_en_i with rx_frame_i=0 is ignored.
- End of frame: rx_frame_i 1->0, as registered in the previous cycle.
- If the count equals the expected count, the next cycle rx_data_o is updated and rx_data_en_o pulses.
- Otherwise rx_error_o pulses, and rx_data_o holds its previous value.
- The counter clears at frame end.
- A frame ended by a reset produces no pulse.
- rx_data_en_o and rx_error_o are mutually exclusive.
- Reset mid-transmission aborts immediately: tx_frame_o drops and no tx_done_o is issued.

Optional Feature:
SERIAL_3WIRE_PARITY_EN
- Defined: TX appends one even-parity bit (XOR of the data bits) after the LSB. RX expects W+1 bits and checks parity. A parity mismatch or a count mismatch gives rx_error_o.
- Undefined: no parity bit is sent. RX expects exactly W bits, and rx_error_o flags count mismatch only.

Decomposition:
- Package serial_3wire_pkg: TX state enum, default DATA_WIDTH/BIT_PERIOD constants, and an expected-bit-count function (honouring the macro).
- Natural split: TX serializer sub-module serial_3wire_ser, with RX deserialisation in the top.

Test Plan:
- Loopback (tx_* wired to rx_*): send 0xAACC5533 -> rx_data_o=0xAACC5533 with one rx_data_en_o pulse; tx_done_o pulses once when tx_busy_o falls; 32 tx_bit_en_o pulses (33 with parity).
- Back-to-back sends: 0x3355CCAA, then 0xFFFFFFFF, then 0x00000000, each issued 200 ns after the previous tx_done_o -> three correct rx words in order, no rx_error_o.
- Request while busy: assert tx_data_en_i with 0x12345678 mid-frame -> ignored; only the original word is received.
- Short frame: drive rx_frame_i high with 31 strobes then low -> rx_error_o pulse, rx_data_o unchanged, no rx_data_en_o.
- Strobes outside frame: rx_bit_en_i pulses with rx_frame_i=0, then a valid 32-bit frame of 0xDEADBEEF -> rx_data_o=0xDEADBEEF, no error.
- Parity (macro defined): flip the parity bit on 0xAACC5533 -> rx_error_o pulse. Separately, assert rst_asy_n_i low mid-frame -> all outputs 0 and no tx_done_o.
